rom_burst_arbiter: RTL and testbench

//   Shares one synchronous-read block ROM (1-cycle read latency, registered output) between
//   N_REQ requesters. Each requester asks for a burst (base address + length). The block

---
 rtl/rom_burst_arbiter.sv | 149 ++++++++++++++
 tb/tb_rom_burst_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
//   Shares one synchronous-read block ROM (1-cycle latency, registered output)
//   between N_REQ requesters. A requester presents a burst (base, len). The
//   block grants round-robin, walks the ROM address for the granted burst and
//   returns the beats tagged with the owner id and a last-beat flag.
//
// Ports
//   clk        clock, all state on posedge
//   rst_n      asynchronous reset, active low
//   req_valid  per-requester request pending
//   req_base   per-requester start address, requester i at [i*AW +: AW]
//   req_len    per-requester beat count 0..L, requester i at [i*(AW+1) +: AW+1]
//   req_ready  one-hot grant (only while idle); accept = req_valid & req_ready
//   rom_addr   address to the ROM
//   rom_data   ROM registered read data
//   rsp_valid  beat valid (no backpressure)
//   rsp_data   beat data, taken straight from rom_data
//   rsp_id     requester owning the beat
//   rsp_last   final beat of the burst
//   busy       burst in progress
module rom_burst_arbiter #(
   parameter int N_REQ = 2,
   parameter int W     = 8,
   parameter int L     = 32,
   localparam int IW   = $clog2(N_REQ),
   localparam int AW   = $clog2(L),
   localparam int IDW  = (IW > 1) ? IW : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*AW-1:0]     req_base,
   input  logic [N_REQ*(AW+1)-1:0] req_len,
   output logic [N_REQ-1:0]        req_ready,
   output logic [AW-1:0]           rom_addr,
   input  logic [W-1:0]            rom_data,
   output logic                    rsp_valid,
   output logic [W-1:0]            rsp_data,
   output logic [IDW-1:0]          rsp_id,
   output logic                    rsp_last,
   output logic                    busy
);

   typedef enum logic [0:0] {S_IDLE, S_BURST} state_t;

   localparam logic [AW-1:0] ADDR_MAX = AW'(L - 1);
   localparam logic [IW-1:0] PTR_MAX  = IW'(N_REQ - 1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_ZERO = '0;

   state_t          state_q;
   state_t          state_d;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   id_q;
   logic [AW:0]     cnt;
   logic [AW-1:0]   cur_addr;

   logic            grant_found;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   cand;
   logic            accept;
   logic [AW-1:0]   sel_base;
   logic [AW:0]     sel_len;

   // Circular index rr_ptr + off folded back into 0..N_REQ-1.
   function automatic logic [IW-1:0] wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      if (s >= N_REQ) s = s - N_REQ;
      return IW'(s);
   endfunction

   // First pending requester at or after rr_ptr, searching circularly.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = wrap_idx(int'(rr_ptr), k);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign sel_base = req_base[grant_idx*AW +: AW];
   assign sel_len  = req_len[grant_idx*(AW+1) +: AW+1];

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
               accept               = 1'b1;
               // A zero-length request is consumed without leaving IDLE.
               if (sel_len != CNT_ZERO) state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (cnt == CNT_ONE) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_ptr    <= '0;
         id_q      <= '0;
         cnt       <= '0;
         cur_addr  <= '0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_id    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rr_ptr <= (grant_idx == PTR_MAX) ? '0 : grant_idx + 1'b1;
            id_q   <= grant_idx;
            if (sel_len != CNT_ZERO) begin
               cur_addr <= sel_base;
               cnt      <= sel_len;
            end
         end
         // Every BURST edge issues one address; the ROM registers the data on
         // that same edge, so the registered valid lines up with rom_data.
         if (state_q == S_BURST) begin
            cur_addr  <= (cur_addr == ADDR_MAX) ? '0 : cur_addr + 1'b1;
            cnt       <= cnt - CNT_ONE;
            rsp_valid <= 1'b1;
            rsp_id    <= IDW'(id_q);
            rsp_last  <= (cnt == CNT_ONE);
         end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
         end
      end
   end

   assign rom_addr = cur_addr;
   assign rsp_data = rom_data;
   assign busy     = (state_q == S_BURST);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb_rom_burst_arbiter
//   Directed bench for rom_burst_arbiter with a behavioural registered-output
//   ROM. Single-requester bursts come from a vector table; fairness, zero
//   length and reset-mid-burst are hand-written sequences.
module tb_rom_burst_arbiter;

   localparam int N_REQ = 2;
   localparam int W     = 8;
   localparam int L     = 32;
   localparam int AW    = 5;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*AW-1:0]     req_base;
   logic [N_REQ*(AW+1)-1:0] req_len;
   logic [N_REQ-1:0]        req_ready;
   logic [AW-1:0]           rom_addr;
   logic [W-1:0]            rom_data;
   logic                    rsp_valid;
   logic [W-1:0]            rsp_data;
   logic [0:0]              rsp_id;
   logic                    rsp_last;
   logic                    busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rom_burst_arbiter #(.N_REQ(N_REQ), .W(W), .L(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_base  (req_base),
      .req_len   (req_len),
      .req_ready (req_ready),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_last  (rsp_last),
      .busy      (busy)
   );

   // ROM contents: 29 is odd, so every address holds a distinct byte.
   function automatic logic [7:0] rom_val(input int a);
      return 8'(a * 29 + 11);
   endfunction

   always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

   typedef struct {
      int r;
      int base;
      int len;
      int exp_first;
      int exp_last;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic set_req(input int r, input int base, input int len);
      req_base[r*AW +: AW]       = AW'(base);
      req_len[r*(AW+1) +: AW+1]  = (AW+1)'(len);
   endtask

   // One burst from requester r with nobody else requesting.
   task automatic do_burst(input int r, input int base, input int len,
                           input int ef, input int el);
      int n;
      logic [7:0] first_d;
      logic [7:0] last_d;
      first_d = '0;
      last_d  = '0;
      set_req(r, base, len);
      req_valid[r] = 1'b1;
      #1;
      n = 0;
      while (req_ready[r] !== 1'b1 && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("grant", 32'(req_ready), 32'(1) << r);
      if (req_ready[r] !== 1'b1) begin
         req_valid[r] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
      #1;
      chk("ready_pulse", 32'(req_ready), 0);
      chk("busy_after_accept", 32'(busy), (len > 0) ? 1 : 0);
      for (int k = 0; k < len; k++) begin
         @(posedge clk);
         #1;
         chk("beat_valid", 32'(rsp_valid), 1);
         chk("beat_data", 32'(rsp_data), 32'(rom_val((base + k) % L)));
         chk("beat_id", 32'(rsp_id), r);
         chk("beat_last", 32'(rsp_last), (k == len - 1) ? 1 : 0);
         chk("beat_busy", 32'(busy), (k + 1 < len) ? 1 : 0);
         if (k == 0) first_d = rsp_data;
         if (k == len - 1) last_d = rsp_data;
      end
      if (len > 0) begin
         chk("first_addr", 32'(first_d), 32'(rom_val(ef)));
         chk("last_addr", 32'(last_d), 32'(rom_val(el)));
      end
      @(posedge clk);
      #1;
      chk("tail_valid", 32'(rsp_valid), 0);
      chk("tail_last", 32'(rsp_last), 0);
      chk("tail_busy", 32'(busy), 0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants;
      int last_c;
      int exp_g;
      int beats;
      int lasts;

      req_valid = '0;
      req_base  = '0;
      req_len   = '0;
      rst_n     = 1'b1;
      #1;
      rst_n     = 1'b0;
      #1;
      // Reset state before any clock edge.
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_last", 32'(rsp_last), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_addr", 32'(rom_addr), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      vecs[0] = '{0, 3, 4, 3, 6};      // single burst
      vecs[1] = '{1, 30, 4, 30, 1};    // address wrap
      vecs[2] = '{0, 5, 32, 5, 4};     // full ROM sweep
      vecs[3] = '{1, 31, 1, 31, 31};   // one beat at top address
      vecs[4] = '{0, 17, 0, 0, 0};     // zero length
      for (int i = 0; i < 5; i++)
         do_burst(vecs[i].r, vecs[i].base, vecs[i].len, vecs[i].exp_first, vecs[i].exp_last);

      // Zero-length request still advances the round-robin pointer.
      do_reset();
      do_burst(0, 9, 0, 0, 0);
      set_req(0, 2, 1);
      set_req(1, 12, 1);
      req_valid = 2'b11;
      #1;
      chk("zero_len_rr", 32'(req_ready), 2);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(posedge clk);
      #1;
      chk("zero_len_beat_id", 32'(rsp_id), 1);
      chk("zero_len_beat_data", 32'(rsp_data), 32'(rom_val(12)));
      @(negedge clk);
      @(negedge clk);

      // Fairness: both held valid with len 2 -> strict alternation, 3-cycle spacing.
      do_reset();
      set_req(0, 10, 2);
      set_req(1, 20, 2);
      req_valid = 2'b11;
      #1;
      grants = 0;
      last_c = -1;
      exp_g  = 0;
      beats  = 0;
      lasts  = 0;
      for (int c = 0; c < 100 && grants < 20; c++) begin
         if (req_ready != '0) begin
            chk("fair_grant", 32'(req_ready), 32'(1) << exp_g);
            if (last_c >= 0) chk("fair_gap", c - last_c, 3);
            last_c = c;
            exp_g  = 1 - exp_g;
            grants++;
         end
         @(posedge clk);
         #1;
         if (rsp_valid) beats++;
         if (rsp_last) lasts++;
         @(negedge clk);
      end
      req_valid = '0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) beats++;
         if (rsp_last) lasts++;
      end
      chk("fair_grants", grants, 20);
      chk("fair_beats", beats, 40);
      chk("fair_lasts", lasts, 20);
      @(negedge clk);

      // Reset in the middle of an 8-beat burst.
      do_reset();
      set_req(0, 0, 8);
      req_valid = 2'b01;
      #1;
      chk("mid_grant", 32'(req_ready), 1);
      @(posedge clk);
      #1;
      req_valid = '0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
      end
      chk("mid_beat3_valid", 32'(rsp_valid), 1);
      chk("mid_beat3_data", 32'(rsp_data), 32'(rom_val(2)));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_last", 32'(rsp_last), 0);
      chk("mid_rst_addr", 32'(rom_addr), 0);
      set_req(0, 7, 1);
      set_req(1, 8, 1);
      req_valid = 2'b11;
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("mid_in_rst_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_after_rst_grant", 32'(req_ready), 1);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(posedge clk);
      #1;
      chk("mid_after_rst_id", 32'(rsp_id), 0);
      chk("mid_after_rst_data", 32'(rsp_data), 32'(rom_val(7)));
      @(posedge clk);
      #1;
      chk("mid_after_rst_idle", 32'(rsp_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
